// File: rtl/router_psum_mc_if.sv
// Psum router bus: PE-cluster snapshot inputs, GLB write handshake, GLB read port and status.
// master: the router. slave: the PE cluster / GLB side.
interface router_psum_mc_if #(
  parameter int unsigned DATA_BITWIDTH     = 16,
  parameter int unsigned ADDR_BITWIDTH_GLB = 10,
  parameter int unsigned NUM_CH            = 3,
  parameter int unsigned PSUMS_PER_CH      = 3
);
  localparam int unsigned NumPsums = NUM_CH * PSUMS_PER_CH;

  // Channel-major: index = ch*PSUMS_PER_CH + idx
  logic [DATA_BITWIDTH-1:0]     r_data_spad_psum [NumPsums];
  logic                         write_psum_ctrl;
  logic                         w_ready_glb;
  logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum;
  logic [DATA_BITWIDTH-1:0]     w_data_glb_psum;
  logic                         write_en_glb_psum;
  logic                         read_en_glb_psum;
  logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_psum;
  logic [DATA_BITWIDTH-1:0]     r_data_glb_psum;
  logic                         busy;
  logic                         pass_done;
  logic                         err_overrun;

  modport master (
    input  r_data_spad_psum, write_psum_ctrl, w_ready_glb, r_data_glb_psum,
    output w_addr_glb_psum, w_data_glb_psum, write_en_glb_psum,
    output read_en_glb_psum, r_addr_glb_psum, busy, pass_done, err_overrun
  );

  modport slave (
    output r_data_spad_psum, write_psum_ctrl, w_ready_glb, r_data_glb_psum,
    input  w_addr_glb_psum, w_data_glb_psum, write_en_glb_psum,
    input  read_en_glb_psum, r_addr_glb_psum, busy, pass_done, err_overrun
  );
endinterface

// File: rtl/router_psum_mc.sv
// Multi-channel psum router: snapshots NUM_CH*PSUMS_PER_CH psums on request and streams them
// into the GLB psum bank with a valid/ready write handshake and per-pass iteration addressing.
// Optional macro PSUM_ACCUM_EN: on iter != 0 each element is read back from the GLB, summed
// with the snapshot and written (read-modify-write).
module router_psum_mc #(
  parameter int unsigned DATA_BITWIDTH     = 16,
  parameter int unsigned ADDR_BITWIDTH_GLB = 10,
  parameter int unsigned NUM_CH            = 3,
  parameter int unsigned PSUMS_PER_CH      = 3,
  parameter int unsigned NUM_ITER          = 8,
  parameter int unsigned PSUM_LOAD_ADDR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  router_psum_mc_if.master  io_bus
);

  localparam int unsigned NumPsums = NUM_CH * PSUMS_PER_CH;
  localparam int unsigned ElemW    = (NumPsums > 1) ? $clog2(NumPsums) : 1;
  localparam int unsigned IterW    = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam logic [ElemW-1:0] LastElem = ElemW'(NumPsums - 1);
  localparam logic [IterW-1:0] LastIter = IterW'(NUM_ITER - 1);
  localparam logic [ADDR_BITWIDTH_GLB-1:0] BaseAddr = ADDR_BITWIDTH_GLB'(PSUM_LOAD_ADDR);

`ifdef PSUM_ACCUM_EN
  typedef enum logic [2:0] {StIdle, StCapture, StWriteGlb, StRdGlb, StRdWait, StAcc} state_e;
`else
  typedef enum logic [1:0] {StIdle, StCapture, StWriteGlb} state_e;
`endif

  // A(e) = base + iter*NumPsums + e, wrapping at the GLB address width
  function automatic logic [ADDR_BITWIDTH_GLB-1:0] addr_of(input logic [IterW-1:0] it,
                                                           input logic [ElemW-1:0] el);
    logic [31:0] sum;
    sum = 32'(PSUM_LOAD_ADDR) + 32'(it) * 32'(NumPsums) + 32'(el);
    return ADDR_BITWIDTH_GLB'(sum);
  endfunction

  state_e                       r_state, w_state_nxt;
  logic [ElemW-1:0]             r_elem, w_elem_nxt, w_elem_inc;
  logic [IterW-1:0]             r_iter, w_iter_nxt;
  logic                         r_wen, w_wen_nxt;
  logic [ADDR_BITWIDTH_GLB-1:0] r_waddr, w_waddr_nxt;
  logic [DATA_BITWIDTH-1:0]     r_wdata, w_wdata_nxt;
  logic                         r_pass_done, w_pass_done_nxt;
  logic                         r_err, w_err_nxt;
  logic [DATA_BITWIDTH-1:0]     r_snap [NumPsums];
  logic                         w_capture;
  logic                         w_busy;
  logic                         w_accept;
  logic                         w_final_accept;

`ifdef PSUM_ACCUM_EN
  logic                         r_ren, w_ren_nxt;
  logic [ADDR_BITWIDTH_GLB-1:0] r_raddr, w_raddr_nxt;
  logic                         w_accum;
  assign w_accum = (r_iter != '0);
`endif

  assign w_elem_inc     = r_elem + 1'b1;
  assign w_busy         = (r_state != StIdle);
  assign w_accept       = (r_state == StWriteGlb) && r_wen && io_bus.w_ready_glb;
  assign w_final_accept = w_accept && (r_elem == LastElem);

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_elem_nxt      = r_elem;
    w_iter_nxt      = r_iter;
    w_wen_nxt       = r_wen;
    w_waddr_nxt     = r_waddr;
    w_wdata_nxt     = r_wdata;
    w_pass_done_nxt = 1'b0;
    w_capture       = 1'b0;
    // A request coinciding with the final acceptance is dropped silently
    w_err_nxt       = r_err | (io_bus.write_psum_ctrl && w_busy && !w_final_accept);
`ifdef PSUM_ACCUM_EN
    w_ren_nxt       = 1'b0;
    w_raddr_nxt     = r_raddr;
`endif
    unique case (r_state)
      StIdle: begin
        w_wen_nxt = 1'b0;
        if (io_bus.write_psum_ctrl) w_state_nxt = StCapture;
      end
      StCapture: begin
        w_capture  = 1'b1;
        w_elem_nxt = '0;
`ifdef PSUM_ACCUM_EN
        if (w_accum) begin
          w_state_nxt = StRdGlb;
          w_ren_nxt   = 1'b1;
          w_raddr_nxt = addr_of(r_iter, '0);
        end else
`endif
        begin
          w_state_nxt = StWriteGlb;
          w_wen_nxt   = 1'b1;
          w_waddr_nxt = addr_of(r_iter, '0);
          // Snapshot register loads on this same edge, so take element 0 from the inputs
          w_wdata_nxt = io_bus.r_data_spad_psum[0];
        end
      end
      StWriteGlb: begin
        if (w_accept) begin
          if (r_elem == LastElem) begin
            w_wen_nxt   = 1'b0;
            w_state_nxt = StIdle;
            w_elem_nxt  = '0;
            if (r_iter == LastIter) begin
              w_iter_nxt      = '0;
              w_pass_done_nxt = 1'b1;
            end else begin
              w_iter_nxt = r_iter + 1'b1;
            end
          end else begin
            w_elem_nxt = w_elem_inc;
`ifdef PSUM_ACCUM_EN
            if (w_accum) begin
              w_wen_nxt   = 1'b0;
              w_state_nxt = StRdGlb;
              w_ren_nxt   = 1'b1;
              w_raddr_nxt = addr_of(r_iter, w_elem_inc);
            end else
`endif
            begin
              w_waddr_nxt = addr_of(r_iter, w_elem_inc);
              w_wdata_nxt = r_snap[w_elem_inc];
            end
          end
        end
      end
`ifdef PSUM_ACCUM_EN
      StRdGlb: begin
        w_state_nxt = StRdWait;
      end
      StRdWait: begin
        w_state_nxt = StAcc;
      end
      StAcc: begin
        // GLB read data is valid in this cycle, two cycles after the strobe
        w_wdata_nxt = io_bus.r_data_glb_psum + r_snap[r_elem];
        w_waddr_nxt = addr_of(r_iter, r_elem);
        w_wen_nxt   = 1'b1;
        w_state_nxt = StWriteGlb;
      end
`endif
      default: begin
        w_state_nxt = StIdle;
        w_wen_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_elem      <= '0;
      r_iter      <= '0;
      r_wen       <= 1'b0;
      r_waddr     <= BaseAddr;
      r_wdata     <= '0;
      r_pass_done <= 1'b0;
      r_err       <= 1'b0;
`ifdef PSUM_ACCUM_EN
      r_ren       <= 1'b0;
      r_raddr     <= BaseAddr;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_elem      <= w_elem_nxt;
      r_iter      <= w_iter_nxt;
      r_wen       <= w_wen_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_pass_done <= w_pass_done_nxt;
      r_err       <= w_err_nxt;
`ifdef PSUM_ACCUM_EN
      r_ren       <= w_ren_nxt;
      r_raddr     <= w_raddr_nxt;
`endif
    end
  end

  // Snapshot register, loaded once per request in CAPTURE
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NumPsums); i++) r_snap[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < int'(NumPsums); i++) r_snap[i] <= io_bus.r_data_spad_psum[i];
    end
  end

  assign io_bus.write_en_glb_psum = r_wen;
  assign io_bus.w_addr_glb_psum   = r_waddr;
  assign io_bus.w_data_glb_psum   = r_wdata;
  assign io_bus.busy              = w_busy;
  assign io_bus.pass_done         = r_pass_done;
  assign io_bus.err_overrun       = r_err;

`ifdef PSUM_ACCUM_EN
  assign io_bus.read_en_glb_psum  = r_ren;
  assign io_bus.r_addr_glb_psum   = r_raddr;
`else
  assign io_bus.read_en_glb_psum  = 1'b0;
  assign io_bus.r_addr_glb_psum   = BaseAddr;
  logic w_unused_rdata;
  assign w_unused_rdata = ^io_bus.r_data_glb_psum;
`endif

endmodule

// File: doc/router_psum_mc.md
Name: router_psum_mc

Overview:
Multi-channel successor to the single-row psum router. Captures a snapshot of psums from NUM_CH PE channels, each with PSUMS_PER_CH entries, on a request from the PE cluster. Streams the snapshot serially into the psum GLB with a valid/ready write handshake, computed addressing and an iteration counter that wraps per pass. Sits between the PE-cluster psum scratchpads and the GLB psum bank.

Parameters:
DATA_BITWIDTH, 16, psum word width
ADDR_BITWIDTH_GLB, 10, GLB address width
NUM_CH, 3, number of PE channels captured per request
PSUMS_PER_CH, 3, psums per channel (kernel_size)
NUM_ITER, 8, iterations per pass before iter wraps
PSUM_LOAD_ADDR, 0, GLB base address

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
r_data_spad_psum  in  DATA_BITWIDTH x [0:NUM_CH*PSUMS_PER_CH-1]  flattened channel-major psum inputs; index = ch*PSUMS_PER_CH+idx
write_psum_ctrl  in  1  request: capture and write a snapshot
w_ready_glb  in  1  GLB accepts a write this cycle
w_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB write address
w_data_glb_psum  out  DATA_BITWIDTH  GLB write data
write_en_glb_psum  out  1  write valid
read_en_glb_psum  out  1  GLB read strobe (accumulate mode only)
r_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB read address
r_data_glb_psum  in  DATA_BITWIDTH  GLB read data, valid 2 cycles after the strobe
busy  out  1  high in every state other than IDLE
pass_done  out  1  one-cycle pulse when iter wraps
err_overrun  out  1  sticky flag: request arrived while busy

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; iter=0; element counter=0; all outputs 0, except both addresses, which reset to PSUM_LOAD_ADDR.
- States: IDLE, CAPTURE, WRITE_GLB. Accumulate build adds RD_GLB, RD_WAIT and ACC.
- IDLE: write_psum_ctrl=1 moves to CAPTURE. Otherwise write_en_glb_psum=0.
- CAPTURE (one cycle): all NUM_CH*PSUMS_PER_CH inputs are registered. Element counter e=0. Next state is WRITE_GLB (or RD_GLB).
- WRITE_GLB: present the registered outputs write_en=1, addr=A(e), data=snapshot[e].
  - A(e) = PSUM_LOAD_ADDR + iter*NUM_CH*PSUMS_PER_CH + e, truncated modulo 2^ADDR_BITWIDTH_GLB.
  - Outputs hold stable while w_ready_glb=0.
  - On a cycle with write_en && w_ready_glb, the write is accepted. e increments and the next element is presented on the next cycle; no bubble in the non-accumulate build.
  - On acceptance of e = NUM_CH*PSUMS_PER_CH-1, the block drops write_en next cycle and returns to IDLE.
  - On that same acceptance, iter increments. If iter was NUM_ITER-1 it wraps to 0 and pass_done pulses for one cycle.
- First write is valid 2 cycles after the request cycle. With w_ready_glb tied high, a snapshot takes NUM_CH*PSUMS_PER_CH+2 cycles from request to the return to IDLE.
- write_psum_ctrl while busy: ignored and err_overrun=1 (sticky until reset). Exception: write_psum_ctrl in the same cycle as the final acceptance is also ignored and does not set err_overrun. The request must be reissued in IDLE.
- Reset mid-stream: the operation aborts and all state clears next edge, including iter; the partial snapshot is not resumed.
- Counter widths are $clog2 of their ranges, minimum 1 bit.

Optional Feature:
Macro PSUM_ACCUM_EN.
- Defined, iter==0: behaves exactly as described above.
- Defined, iter!=0: each element does a read-modify-write:
  - RD_GLB: read_en=1, r_addr=A(e) for one cycle.
  - RD_WAIT: one cycle.
  - ACC: sum = r_data_glb_psum + snapshot[e], wrapping modulo 2^DATA_BITWIDTH.
  - WRITE_GLB then writes sum with the same handshake, then returns to RD_GLB for the next element.
  - Cost: 3 extra cycles per element.
- Undefined: RD/ACC logic is absent; read_en_glb_psum=0; r_addr_glb_psum=PSUM_LOAD_ADDR; r_data_glb_psum is ignored.

Test Plan:
- Basic: reset, w_ready high, inputs 1..9, pulse ctrl -> writes addr 0..8, data 1..9 on consecutive cycles; first write 2 cycles after ctrl; busy falls after the 9th write; iter=1.
- Second snapshot: same as Basic, then a second ctrl with inputs 10..18 -> addresses 9..17.
- Backpressure: w_ready low for 3 cycles at e=4 -> addr 4 / data 5 held stable for 3 cycles; no element skipped or duplicated.
- Wrap: NUM_ITER=2, three snapshots -> pass_done pulses once after the 2nd; 3rd snapshot writes addr 0..8.
- Overrun and reset: ctrl pulsed at e=3 -> err_overrun=1 and the stream is unaffected. Then reset low mid-stream -> write_en=0, addr=PSUM_LOAD_ADDR, iter=0, err_overrun=0.
- PSUM_ACCUM_EN: pass 0 writes 1..9; on pass 1 the bench model returns stored values -> inputs 1..9 on iter 1 read addr 9..17 holding 100 each and write 101..109 there. With stored value 0xFFFF and input 2 -> writes 0x0001.
